sram_bist_ctrl: RTL

Parametrised built-in self-test controller for N parallel external SRAM chips addressed by an external ripple counter (reset/clock driven by this block). Writes an LFSR pattern sequence to 2^DEPTH_LOG2 words, resets the counter and reads the words back. The read-back expected pattern is regenerated from the seed, so no pattern storage is needed. Optional second pass with inverted data. Reports pass/fail, error count, first failing address and per-chip fail flags. Sits between the board top level (which owns the tristate buffers) and the SRAM/counter pins.

---
 rtl/sram_bist_ctrl_if.sv | 37 +++
 rtl/sram_bist_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sram_bist_ctrl_if.sv
// Pin bundle between the BIST controller and the board top level / SRAM side.
// slave = controller, master = board/test side.
interface sram_bist_ctrl_if #(
    parameter int CHANNELS   = 2,
    parameter int CH_WIDTH   = 4,
    parameter int DEPTH_LOG2 = 4
);
    localparam int W = CHANNELS * CH_WIDTH;

    logic                  START;
    logic                  MODE;
    logic [W-1:0]          SEED;
    logic                  COUNTER_CLK;
    logic                  COUNTER_RST;
    logic                  WE_BAR;
    logic                  DATA_OE;
    logic [W-1:0]          DATA_OUT;
    logic [W-1:0]          DATA_IN;
    logic                  BUSY;
    logic                  DONE;
    logic                  PASS;
    logic [DEPTH_LOG2+1:0] ERR_COUNT;
    logic [DEPTH_LOG2-1:0] FIRST_ERR_ADDR;
    logic [CHANNELS-1:0]   CH_FAIL;

    modport master (
        output START, MODE, SEED, DATA_IN,
        input  COUNTER_CLK, COUNTER_RST, WE_BAR, DATA_OE, DATA_OUT,
               BUSY, DONE, PASS, ERR_COUNT, FIRST_ERR_ADDR, CH_FAIL
    );

    modport slave (
        input  START, MODE, SEED, DATA_IN,
        output COUNTER_CLK, COUNTER_RST, WE_BAR, DATA_OE, DATA_OUT,
               BUSY, DONE, PASS, ERR_COUNT, FIRST_ERR_ADDR, CH_FAIL
    );
endinterface

// File: rtl/sram_bist_ctrl.sv
// SRAM BIST controller: writes an LFSR sequence through an external address counter,
// then regenerates it from the seed to check the read-back, optionally with inverted data.
module sram_bist_ctrl #(
    parameter int CHANNELS   = 2,
    parameter int CH_WIDTH   = 4,
    parameter int DEPTH_LOG2 = 4,
    parameter int CLK_DIV    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    sram_bist_ctrl_if.slave  bus
);
    localparam int W  = CHANNELS * CH_WIDTH;
    localparam int SW = $clog2(CLK_DIV);
    localparam int EW = DEPTH_LOG2 + 2;

    localparam logic [31:0] TAPS32 = (W == 4)  ? 32'h0000_000C :
                                     (W == 8)  ? 32'h0000_00B8 :
                                     (W == 16) ? 32'h0000_D008 : 32'h8020_0003;
    localparam logic [W-1:0]          TAPS      = TAPS32[W-1:0];
    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;
    localparam logic [SW-1:0]         S_LAST    = SW'(CLK_DIV - 1);
    localparam logic [SW-1:0]         S_CMP     = SW'(CLK_DIV - 2);
    localparam logic [SW-1:0]         S_WE_END  = SW'(CLK_DIV - 3);
    localparam logic [SW-1:0]         S_OE_BEG  = SW'(1);
    localparam logic [SW-1:0]         S_WE_BEG  = SW'(2);

    if (!(W == 4 || W == 8 || W == 16 || W == 32) || CLK_DIV < 8 || (CLK_DIV % 2) != 0) begin : g_bad_param
        $error("sram_bist_ctrl: data width must be 4/8/16/32 and CLK_DIV even and >= 8");
    end

    typedef enum logic [2:0] {IDLE, CLR_W, WRITE, CLR_R, READ, FIN} state_t;

    state_t                state, state_n;
    logic [SW-1:0]         s, s_n;
    logic [DEPTH_LOG2-1:0] addr, addr_n;
    logic [W-1:0]          lfsr, lfsr_n, lfsr_step, seed_q;
    logic                  mode_q, pass_q, pass_n;
    logic                  start_acc, slot_end;
    logic [W-1:0]          expected, mism, pattern_n;
    logic [CHANNELS-1:0]   ch_mism;

    logic [EW-1:0]         err_count;
    logic [DEPTH_LOG2-1:0] first_err_addr;
    logic [CHANNELS-1:0]   ch_fail;

    logic                  we_bar_q, data_oe_q, cclk_q, crst_q, busy_q, done_q;
    logic [W-1:0]          data_out_q;
    logic                  we_bar_n, data_oe_n, cclk_n, crst_n, busy_n, done_n;
    logic [W-1:0]          data_out_n;

    assign start_acc = bus.START && (state == IDLE || state == FIN);
    assign slot_end  = (s == S_LAST);
    assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    assign expected  = pass_q ? ~lfsr : lfsr;
    assign mism      = bus.DATA_IN ^ expected;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign ch_mism[c] = |mism[c*CH_WIDTH +: CH_WIDTH];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            s      <= '0;
            addr   <= '0;
            lfsr   <= '0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_n;
            s      <= s_n;
            addr   <= addr_n;
            lfsr   <= lfsr_n;
            pass_q <= pass_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        addr_n  = addr;
        lfsr_n  = lfsr;
        pass_n  = pass_q;
        if (start_acc) begin
            state_n = CLR_W;
            s_n     = '0;
            pass_n  = 1'b0;
        end else if (state != IDLE && state != FIN) begin
            s_n = slot_end ? '0 : s + SW'(1);
            case (state)
                CLR_W, CLR_R: begin
                    addr_n = '0;
                    lfsr_n = seed_q;
                    if (slot_end) state_n = (state == CLR_W) ? WRITE : READ;
                end
                WRITE, READ: if (slot_end) begin
                    addr_n = addr + DEPTH_LOG2'(1);
                    lfsr_n = lfsr_step;
                    if (addr == LAST_ADDR) begin
                        if (state == WRITE)            state_n = CLR_R;
                        else if (mode_q && !pass_q) begin
                            state_n = CLR_W;
                            pass_n  = 1'b1;
                        end else                       state_n = FIN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pin outputs are decoded from the next state and registered, so WE_BAR/DATA_OE
    // come straight off flops and cannot glitch.
    always_comb begin
        pattern_n  = pass_n ? ~lfsr_n : lfsr_n;
        we_bar_n   = !(state_n == WRITE && s_n >= S_WE_BEG && s_n <= S_WE_END);
        data_oe_n  = (state_n == WRITE && s_n >= S_OE_BEG && s_n <= S_CMP);
        cclk_n     = (state_n == WRITE || state_n == READ) && s_n == S_LAST && addr_n != LAST_ADDR;
        crst_n     = (state_n == CLR_W || state_n == CLR_R);
        data_out_n = (state_n == WRITE) ? pattern_n : '0;
        busy_n     = (state_n != IDLE && state_n != FIN);
        done_n     = (state_n == FIN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_bar_q   <= 1'b1;
            data_oe_q  <= 1'b0;
            cclk_q     <= 1'b0;
            crst_q     <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            we_bar_q   <= we_bar_n;
            data_oe_q  <= data_oe_n;
            cclk_q     <= cclk_n;
            crst_q     <= crst_n;
            data_out_q <= data_out_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seed_q <= '0;
            mode_q <= 1'b0;
        end else if (start_acc) begin
            seed_q <= (bus.SEED == '0) ? W'(1) : bus.SEED;
            mode_q <= bus.MODE;
        end
    end

    // Read data is sampled late in the slot, after the bus has settled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_count      <= '0;
            first_err_addr <= '0;
            ch_fail        <= '0;
        end else if (start_acc) begin
            err_count      <= '0;
            first_err_addr <= '0;
            ch_fail        <= '0;
        end else if (state == READ && s == S_CMP) begin
            ch_fail <= ch_fail | ch_mism;
            if (|mism) begin
                if (err_count == '0) first_err_addr <= addr;
                if (err_count != '1) err_count <= err_count + EW'(1);
            end
        end
    end

    assign bus.WE_BAR         = we_bar_q;
    assign bus.DATA_OE        = data_oe_q;
    assign bus.COUNTER_CLK    = cclk_q;
    assign bus.COUNTER_RST    = crst_q;
    assign bus.DATA_OUT       = data_out_q;
    assign bus.BUSY           = busy_q;
    assign bus.DONE           = done_q;
    assign bus.PASS           = done_q && (err_count == '0);
    assign bus.ERR_COUNT      = err_count;
    assign bus.FIRST_ERR_ADDR = first_err_addr;
    assign bus.CH_FAIL        = ch_fail;
endmodule
